wb_rx_dma_master: RTL and testbench

//  Wishbone initiator that moves a received UDP payload into memory-mapped RX buffer space.

---
 rtl/wb_rx_dma_master_pkg.sv | 25 ++
 rtl/wb_rx_dma_master_if.sv | 29 ++
 rtl/wb_rx_byte_packer.sv | 55 +++++
 rtl/wb_rx_dma_master.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_rx_dma_master.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_rx_dma_master_pkg.sv
// Shared types and constants for the Wishbone RX DMA initiator.
// The length/status word layout is {ovf, 15'b0, len[15:0]}.
package wb_rx_dma_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_LEN_WRITE = 3'd3,
        ST_DRAIN     = 3'd4
    } state_e;

    localparam logic [3:0] SEL_FULL = 4'hF;
    localparam int         OVF_BIT  = 31;
    localparam int         LEN_MSB  = 15;

    function automatic logic [31:0] len_word(input logic ovf, input logic [LEN_MSB:0] len);
        logic [31:0] w;
        w            = '0;
        w[LEN_MSB:0] = len;
        w[OVF_BIT]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/wb_rx_dma_master_if.sv
// Byte-stream input and classic Wishbone write-master signals of the RX DMA block.
// The master modport is the DMA side; slave is the stream source / bus target side.
interface wb_rx_dma_master_if;

    logic        s_data_v;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        input  s_data_v, s_data, s_last, wbm_ack_i, wbm_err_i,
        output s_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output s_data_v, s_data, s_last, wbm_ack_i, wbm_err_i,
        input  s_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wb_rx_byte_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in lane k, its sel bit is set.
// word_o/sel_o include the byte being pushed so the caller can launch on the same edge.
module wb_rx_byte_packer #(
    parameter int unsigned OCT = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [OCT-1:0]     byte_i,
    input  logic               last_i,
    output logic [4*OCT-1:0]   word_o,
    output logic [3:0]         sel_o,
    output logic               word_ready_o,
    output logic               last_o
);

    logic [1:0]       lane_q;
    logic [4*OCT-1:0] word_q;
    logic [3:0]       sel_q;

    always_comb begin
        word_o       = word_q;
        sel_o        = sel_q;
        word_ready_o = push_i && (lane_q == 2'd3 || last_i);
        last_o       = push_i && last_i;
        if (push_i) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_q == 2'(i)) begin
                    word_o[i*OCT +: OCT] = byte_i;
                    sel_o[i]             = 1'b1;
                end
            end
        end
    end

    // A completed word is handed off and the packer restarts at lane 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= 2'd0;
            word_q <= '0;
            sel_q  <= 4'd0;
        end else if (push_i) begin
            if (word_ready_o) begin
                lane_q <= 2'd0;
                word_q <= '0;
                sel_q  <= 4'd0;
            end else begin
                lane_q <= lane_q + 2'd1;
                word_q <= word_o;
                sel_q  <= sel_o;
            end
        end
    end

endmodule

// File: rtl/wb_rx_dma_master.sv
// Wishbone initiator writing a received byte stream as 32-bit words from DST_BASE upward,
// then closing each frame with a {ovf, len} status write to LEN_ADDR.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for the first byte of a frame (s_ready = enable_i)
// COLLECT    | packing bytes into the current word
// WRITE      | data word on the bus, waiting for ack/err/timeout
// LEN_WRITE  | dead cycle, then length/status word on the bus
// DRAIN      | bus error: discard bytes up to s_last
module wb_rx_dma_master
    import wb_rx_dma_master_pkg::*;
#(
    parameter int unsigned OCT       = 8,
    parameter logic [31:0] DST_BASE  = 32'h4000_0000,
    parameter logic [31:0] LEN_ADDR  = 32'h3000_0028,
    parameter int unsigned MAX_WORDS = 512,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                enable_i,
    wb_rx_dma_master_if.master  bus,
    output logic                done_o,
    output logic                err_o,
    output logic [15:0]         frame_len_o
);

    localparam logic [15:0] CAP_BYTES = 16'(MAX_WORDS * 4);
    localparam logic [7:0]  TMR_LOAD  = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             cyc_q, cyc_d;
    logic [31:0]      adr_q, adr_d;
    logic [4*OCT-1:0] dat_q, dat_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      ptr_q, ptr_d;
    logic [15:0]      len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             end_q, end_d;
    logic [7:0]       tmr_q, tmr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [15:0]      flen_q, flen_d;

    logic             s_ready;
    logic             accept;
    logic             store;
    logic             abort;
    logic [4*OCT-1:0] pk_word;
    logic [3:0]       pk_sel;
    logic             pk_ready;
    logic             pk_last;

    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_IDLE:              s_ready = enable_i;
            ST_COLLECT, ST_DRAIN: s_ready = 1'b1;
            default:              s_ready = 1'b0;
        endcase
    end

    assign accept = bus.s_data_v && s_ready;
    // Only IDLE/COLLECT accept into the packer; DRAIN discards.
    assign store  = accept && (state_q != ST_DRAIN) && (len_q < CAP_BYTES);

    wb_rx_byte_packer #(.OCT(OCT)) u_packer (
        .clk_i        (wb_clk_i),
        .rst_ni       (wb_rst_ni),
        .push_i       (store),
        .byte_i       (bus.s_data),
        .last_i       (bus.s_last),
        .word_o       (pk_word),
        .sel_o        (pk_sel),
        .word_ready_o (pk_ready),
        .last_o       (pk_last)
    );

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        end_d   = end_q;
        tmr_d   = tmr_q;
        done_d  = 1'b0;
        err_d   = err_q;
        flen_d  = flen_q;
        abort   = 1'b0;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (accept) begin
                    if (state_q == ST_IDLE) begin
                        err_d = 1'b0;
                    end
                    state_d = ST_COLLECT;
                    if (store) begin
                        len_d = len_q + 16'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (pk_ready) begin
                        cyc_d   = 1'b1;
                        adr_d   = ptr_q;
                        dat_d   = pk_word;
                        sel_d   = pk_sel;
                        tmr_d   = TMR_LOAD;
                        end_d   = pk_last;
                        state_d = ST_WRITE;
                    end else if (bus.s_last) begin
                        // Frame ended on a dropped byte: nothing pending, go straight to status.
                        end_d   = 1'b1;
                        state_d = ST_LEN_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                if (bus.wbm_err_i || (!bus.wbm_ack_i && tmr_q == 8'd0)) begin
                    abort = 1'b1;
                end else if (bus.wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    sel_d   = 4'd0;
                    dat_d   = '0;
                    ptr_d   = ptr_q + 32'd4;
                    state_d = end_q ? ST_LEN_WRITE : ST_COLLECT;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end

            ST_LEN_WRITE: begin
                // Entered with cyc low, which gives the dead cycle before the status write.
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    adr_d = LEN_ADDR;
                    dat_d = len_word(ovf_q, len_q);
                    sel_d = SEL_FULL;
                    tmr_d = TMR_LOAD;
                end else if (bus.wbm_err_i || (!bus.wbm_ack_i && tmr_q == 8'd0)) begin
                    abort = 1'b1;
                end else if (bus.wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    sel_d   = 4'd0;
                    dat_d   = '0;
                    flen_d  = len_q;
                    done_d  = 1'b1;
                    ptr_d   = DST_BASE;
                    len_d   = 16'd0;
                    ovf_d   = 1'b0;
                    end_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end

            ST_DRAIN: begin
                if (accept && bus.s_last) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            cyc_d   = 1'b0;
            sel_d   = 4'd0;
            dat_d   = '0;
            err_d   = 1'b1;
            ptr_d   = DST_BASE;
            len_d   = 16'd0;
            ovf_d   = 1'b0;
            end_d   = 1'b0;
            state_d = end_q ? ST_IDLE : ST_DRAIN;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= '0;
            sel_q   <= 4'd0;
            ptr_q   <= DST_BASE;
            len_q   <= 16'd0;
            ovf_q   <= 1'b0;
            end_q   <= 1'b0;
            tmr_q   <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            flen_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            end_q   <= end_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            flen_q  <= flen_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = cyc_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = sel_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign frame_len_o   = flen_q;

endmodule

// File: tb/tb_wb_rx_dma_master.sv
// Scoreboarded bench for wb_rx_dma_master: a byte driver pushes expected bus writes,
// a Wishbone slave model pops and compares them as strobes appear.
module tb_wb_rx_dma_master;

    localparam int          MAXW = 2;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] LADR = 32'h3000_0028;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        done_o;
    logic        err_o;
    logic [15:0] frame_len_o;

    wb_rx_dma_master_if bus();

    wb_rx_dma_master #(.MAX_WORDS(MAXW)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .enable_i    (enable),
        .bus         (bus),
        .done_o      (done_o),
        .err_o       (err_o),
        .frame_len_o (frame_len_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] frm[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         n_wr = 0;
    int         ack_dly = 0;
    int         err_at = -1;
    bit         no_ack = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic load_frame(input int n, input logic [7:0] first, input logic [7:0] step);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'(first + i * step));
    endtask

    // Reference: words of up to four bytes from BASE, capped at MAXW words, then status word.
    task automatic model_frame();
        int          n;
        int          stored;
        logic [31:0] w;
        logic [3:0]  s;
        n      = frm.size();
        stored = (n > MAXW * 4) ? MAXW * 4 : n;
        for (int i = 0; i < stored; i += 4) begin
            w = '0;
            s = '0;
            for (int k = 0; k < 4 && i + k < stored; k++) begin
                w[8*k +: 8] = frm[i+k];
                s[k]        = 1'b1;
            end
            sb.push_back('{adr: BASE + 32'(i), dat: w, sel: s});
        end
        sb.push_back('{adr: LADR, dat: {1'(n > MAXW * 4), 15'b0, 16'(stored)}, sel: 4'hF});
    endtask

    task automatic send_frame(input int en_off_at);
        int guard;
        for (int i = 0; i < frm.size(); i++) begin
            @(negedge clk);
            bus.s_data_v = 1'b1;
            bus.s_data   = frm[i];
            bus.s_last   = (i == frm.size() - 1);
            guard = 0;
            while (!bus.s_ready && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 1000) begin
                chk_eq("byte_hs_timeout", 32'(guard), 32'd0);
                break;
            end
            @(posedge clk);
            if (i == en_off_at) #1 enable = 1'b0;
        end
        @(negedge clk);
        bus.s_data_v = 1'b0;
        bus.s_last   = 1'b0;
    endtask

    task automatic wait_done(input logic [15:0] exp_len);
        int g;
        g = 0;
        while (!done_o && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk_eq("done_seen", 32'(done_o), 32'd1);
        chk_eq("frame_len", 32'(frame_len_o), 32'(exp_len));
        @(negedge clk);
        chk_eq("done_pulse_width", 32'(done_o), 32'd0);
        chk_eq("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin : wb_slave
        logic [31:0] a0;
        logic [31:0] d0;
        logic [3:0]  s0;
        wr_t         e;
        int          cnt;
        bit          aborted;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.wbm_cyc_o) begin
                n_wr++;
                a0 = bus.wbm_adr_o;
                d0 = bus.wbm_dat_o;
                s0 = bus.wbm_sel_o;
                chk_eq("stb_eq_cyc", 32'(bus.wbm_stb_o), 32'd1);
                chk_eq("we_eq_cyc", 32'(bus.wbm_we_o), 32'd1);
                chk_eq("sb_avail", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk_eq("wr_adr", a0, e.adr);
                    chk_eq("wr_dat", d0, e.dat);
                    chk_eq("wr_sel", 32'(s0), 32'(e.sel));
                end
                if (no_ack) begin
                    cnt = 1;
                    while (cnt < 400) begin
                        @(negedge clk);
                        if (!bus.wbm_cyc_o) break;
                        cnt++;
                    end
                    chk_eq("timeout_cycles", 32'(cnt), 32'd255);
                    chk_eq("timeout_err", 32'(err_o), 32'd1);
                end else begin
                    aborted = 1'b0;
                    for (int i = 0; i < ack_dly; i++) begin
                        @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        chk_eq("hold_adr", bus.wbm_adr_o, a0);
                        chk_eq("hold_dat", bus.wbm_dat_o, d0);
                        chk_eq("hold_sel", 32'(bus.wbm_sel_o), 32'(s0));
                        chk_eq("hold_stb", 32'(bus.wbm_stb_o), 32'd1);
                        chk_eq("ready_low", 32'(bus.s_ready), 32'd0);
                    end
                    if (!aborted) begin
                        // On the armed write both ack and err are raised; err must win.
                        if (n_wr == err_at) begin
                            bus.wbm_err_i = 1'b1;
                            bus.wbm_ack_i = 1'b1;
                        end else begin
                            bus.wbm_ack_i = 1'b1;
                        end
                        @(negedge clk);
                        bus.wbm_ack_i = 1'b0;
                        bus.wbm_err_i = 1'b0;
                        if (rst_n) chk_eq("dead_cycle", 32'(bus.wbm_cyc_o), 32'd0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g;
        bus.s_data_v = 1'b0;
        bus.s_data   = 8'h00;
        bus.s_last   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        chk_eq("rst_adr", bus.wbm_adr_o, 32'd0);
        chk_eq("rst_dat", bus.wbm_dat_o, 32'd0);
        chk_eq("rst_sel", 32'(bus.wbm_sel_o), 32'd0);
        chk_eq("rst_done", 32'(done_o), 32'd0);
        chk_eq("rst_err", 32'(err_o), 32'd0);
        chk_eq("rst_flen", 32'(frame_len_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("ready_disabled", 32'(bus.s_ready), 32'd0);
        enable = 1'b1;
        #1 chk_eq("ready_enabled", 32'(bus.s_ready), 32'd1);

        // Basic 5-byte frame, immediate ack.
        load_frame(5, 8'h11, 8'h11);
        model_frame();
        send_frame(-1);
        wait_done(16'd5);

        // Same frame, ack held off 10 cycles.
        ack_dly = 10;
        model_frame();
        send_frame(-1);
        wait_done(16'd5);
        ack_dly = 0;

        // Ack never comes: timeout, drain, no status write.
        no_ack = 1'b1;
        load_frame(6, 8'hA0, 8'h01);
        model_frame();
        while (sb.size() > 1) void'(sb.pop_back());
        send_frame(-1);
        @(negedge clk);
        chk_eq("tmo_err_sticky", 32'(err_o), 32'd1);
        repeat (20) @(negedge clk);
        chk_eq("tmo_no_more_wr", 32'(sb.size()), 32'd0);
        chk_eq("tmo_cyc_idle", 32'(bus.wbm_cyc_o), 32'd0);
        no_ack = 1'b0;
        load_frame(4, 8'h01, 8'h01);
        model_frame();
        send_frame(-1);
        chk_eq("err_cleared", 32'(err_o), 32'd0);
        wait_done(16'd4);

        // Overflow at MAXW words, enable dropped mid-frame.
        load_frame(10, 8'h10, 8'h03);
        model_frame();
        send_frame(2);
        wait_done(16'(MAXW * 4));
        chk_eq("ready_after_disable", 32'(bus.s_ready), 32'd0);
        enable = 1'b1;

        // Bus error (with simultaneous ack) on the second data write.
        err_at = n_wr + 2;
        load_frame(10, 8'h50, 8'h01);
        model_frame();
        void'(sb.pop_back());
        send_frame(-1);
        @(negedge clk);
        chk_eq("buserr_err", 32'(err_o), 32'd1);
        repeat (20) @(negedge clk);
        chk_eq("buserr_no_more_wr", 32'(sb.size()), 32'd0);
        chk_eq("buserr_no_done", 32'(done_o), 32'd0);
        err_at = -1;

        // Asynchronous reset while a write is outstanding.
        ack_dly = 20;
        load_frame(4, 8'hC0, 8'h01);
        model_frame();
        void'(sb.pop_back());
        send_frame(-1);
        g = 0;
        while (!bus.wbm_cyc_o && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk_eq("rst_pre_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("async_rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        chk_eq("async_rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        ack_dly = 0;
        chk_eq("rst_sb_empty", 32'(sb.size()), 32'd0);
        load_frame(4, 8'hD0, 8'h01);
        model_frame();
        send_frame(-1);
        wait_done(16'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
